// File: rtl/command_dispatch.sv
// command_dispatch: FIFO-buffered serialiser of hcp write/read commands onto the shared table-RAM bus.
// Optional feature macro DISPATCH_STAT_EN adds executed-write, acked-read and dropped-command counters.
module command_dispatch #(
  parameter int NTBL     = 8,
  parameter int DW       = 64,
  parameter int RD_LAT   = 2,
  parameter int FIFO_DEP = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [203:0]       iv_wr_command,
  input  logic               i_wr_command_wr,
  input  logic [203:0]       iv_rd_command,
  input  logic               i_rd_command_wr,
  output logic [203:0]       ov_rd_command_ack,
  output logic               o_rd_command_ack_wr,
  output logic [11:0]        ov_tbl_addr,
  output logic [DW-1:0]      ov_tbl_wdata,
  output logic [NTBL-1:0]    ov_tbl_wr,
  output logic [NTBL-1:0]    ov_tbl_rd,
  input  logic [NTBL*DW-1:0] iv_tbl_rdata,
  output logic               o_cmd_drop_pulse
`ifdef DISPATCH_STAT_EN
  ,
  output logic [15:0]        ov_wr_cnt,
  output logic [15:0]        ov_rd_cnt,
  output logic [15:0]        ov_drop_cnt
`endif
);

  localparam int AW = (FIFO_DEP > 1) ? $clog2(FIFO_DEP) : 1;
  localparam int CW = $clog2(FIFO_DEP + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t          state, state_nxt;
  logic [204:0]    fifo_mem [FIFO_DEP];
  logic [204:0]    head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, free;
  logic            push_wr, push_rd, drop_wr, drop_rd, pop;
  logic            cur_is_rd, tgt_ok;
  logic [10:0]     cur_tag;
  logic [3:0]      cur_tgt;
  logic [2:0]      wait_cnt;
  logic [DW-1:0]   rd_data, sel_rdata;
  logic [NTBL-1:0] tgt_onehot;
  logic            unused_bits;

  // With both valids and one free slot the write wins; a same-cycle pop does not free a slot.
  always_comb begin
    free    = CW'(FIFO_DEP) - count;
    push_wr = i_wr_command_wr && (free != '0);
    push_rd = i_rd_command_wr && (free > CW'(push_wr));
    drop_wr = i_wr_command_wr && !push_wr;
    drop_rd = i_rd_command_wr && !push_rd;
    pop     = (state == IDLE) && (count != '0);
  end

  assign head        = fifo_mem[rd_ptr];
  assign tgt_ok      = int'(cur_tgt) < NTBL;
  assign tgt_onehot  = NTBL'(1) << cur_tgt;
  assign unused_bits = ^{head[203], head[175:0]};

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NTBL; k++)
      if (int'(cur_tgt) == k) sel_rdata = iv_tbl_rdata[k*DW +: DW];
  end

  // NOTE: storage array has no reset; count/pointers alone define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push_wr) fifo_mem[wr_ptr] <= {1'b0, iv_wr_command};
    if (push_rd) fifo_mem[wr_ptr + AW'(push_wr)] <= {1'b1, iv_rd_command};
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    ov_tbl_wr = '0;
    ov_tbl_rd = '0;
    unique case (state)
      IDLE:  if (count != '0) state_nxt = ISSUE;
      ISSUE: begin
        if (!cur_is_rd) begin
          if (tgt_ok) ov_tbl_wr = tgt_onehot;
          state_nxt = IDLE;
        end else if (tgt_ok) begin
          ov_tbl_rd = tgt_onehot;
          state_nxt = WAIT;
        end else begin
          state_nxt = ACK;
        end
      end
      WAIT:    if (wait_cnt == 3'(RD_LAT - 1)) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state               <= IDLE;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      cur_is_rd           <= 1'b0;
      cur_tag             <= '0;
      cur_tgt             <= '0;
      wait_cnt            <= '0;
      rd_data             <= '0;
      ov_tbl_addr         <= '0;
      ov_tbl_wdata        <= '0;
      ov_rd_command_ack   <= '0;
      o_rd_command_ack_wr <= 1'b0;
      o_cmd_drop_pulse    <= 1'b0;
    end else begin
      state               <= state_nxt;
      wr_ptr              <= wr_ptr + AW'(push_wr) + AW'(push_rd);
      rd_ptr              <= rd_ptr + AW'(pop);
      count               <= count + CW'(push_wr) + CW'(push_rd) - CW'(pop);
      o_cmd_drop_pulse    <= drop_wr | drop_rd;
      o_rd_command_ack_wr <= (state == ACK);
      if (pop) begin
        cur_is_rd   <= head[204];
        cur_tag     <= head[202:192];
        cur_tgt     <= head[191:188];
        ov_tbl_addr <= head[187:176];
        if (!head[204]) ov_tbl_wdata <= head[DW-1:0];
      end
      // Read data defaults to zero so an out-of-range target acks with empty data.
      if (state == ISSUE) begin
        wait_cnt <= '0;
        rd_data  <= '0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 3'd1;
        if (state_nxt == ACK) rd_data <= sel_rdata;
      end
      if (state == ACK)
        ov_rd_command_ack <= {~tgt_ok, cur_tag, cur_tgt, ov_tbl_addr, 176'(rd_data)};
    end
  end

`ifdef DISPATCH_STAT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_wr_cnt   <= '0;
      ov_rd_cnt   <= '0;
      ov_drop_cnt <= '0;
    end else begin
      if (ov_tbl_wr != '0) ov_wr_cnt <= ov_wr_cnt + 16'd1;
      if (state == ACK)    ov_rd_cnt <= ov_rd_cnt + 16'd1;
      ov_drop_cnt <= ov_drop_cnt + 16'(drop_wr) + 16'(drop_rd);
    end
  end
`endif

endmodule
